// File: rtl/keypad_event_queue_pkg.sv
// Shared types and helpers for the keypad event queue: key vector and code
// types, plus a lowest-set-bit finder used by the grant logic.
package keypad_pkg;

  localparam int NUM_KEYS = 16;
  localparam int CODE_W   = $clog2(NUM_KEYS);

  typedef logic [NUM_KEYS-1:0] key_vec_t;
  typedef logic [CODE_W-1:0]   key_code_t;

  typedef struct packed {
    logic      found;
    key_code_t idx;
  } lowest_t;

  // Scan from the top so the last hit written is the lowest index.
  function automatic lowest_t lowest_index(key_vec_t v);
    lowest_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.found = 1'b1;
        r.idx   = key_code_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_event_queue_fifo.sv
// Small synchronous FIFO with registered storage and combinational head read.
// Head data reads as zero while the FIFO is empty.
module sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is only legal when the head leaves this cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/keypad_event_queue.sv
// Turns key press edges into queued 4-bit key codes with a valid/ready output,
// a pending mask for back-pressure, and a sticky lost-press flag.
module keypad_event_queue
  import keypad_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [CODE_W-1:0]   code_data,
  output logic                code_valid,
  input  logic                code_ready,
  output logic [CNT_W-1:0]    count,
  output logic                overflow,
  input  logic                clr_ovf
);

  key_vec_t keys_q, pending_q, pending_d;
  key_vec_t rise, grant;
  logic     overflow_q, overflow_d;
  logic     full, empty, pop, push;
  lowest_t  lo;

  always_comb begin
    rise  = keys & ~keys_q;
    pop   = code_valid & code_ready;
    lo    = lowest_index(pending_q);
    push  = lo.found & (~full | pop);
    grant = '0;
    if (push) grant[lo.idx] = 1'b1;
    pending_d = (pending_q & ~grant) | rise;
    // A key granted this cycle frees its slot, so re-pressing it is not a loss.
    overflow_d = (|(rise & pending_q & ~grant)) | (overflow_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keys_q     <= '1;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      keys_q     <= keys;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(CODE_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (lo.idx),
    .rdata_o (code_data),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign code_valid = ~empty;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Randomised and directed bench for keypad_event_queue: a queue-based model
// predicts pushed codes, count and overflow; a negedge monitor checks the DUT.
module tb_keypad_event_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] keys = 16'h0001;
  logic        code_ready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [3:0]  code_data;
  logic        code_valid;
  logic        overflow;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  int          exp_q[$];
  logic [15:0] mkeys = '1;
  logic [15:0] mpend = '0;
  int          mcnt  = 0;
  bit          movf  = 1'b0;

  always #5 clk = ~clk;

  keypad_event_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .keys       (keys),
    .code_data  (code_data),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .count      (count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: a queue of codes, a set of pending keys and a sticky flag.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mkeys = '1;
      mpend = '0;
      mcnt  = 0;
      movf  = 1'b0;
      exp_q.delete();
    end else begin
      logic [15:0] rise;
      bit          popped;
      int          g;
      rise   = keys & ~mkeys;
      popped = (mcnt != 0) && code_ready;
      g      = -1;
      if (mcnt < DEPTH || popped)
        for (int i = 0; i < 16; i++)
          if (mpend[i] && g < 0) g = i;
      if (g >= 0) begin
        mpend[g] = 1'b0;
        exp_q.push_back(g);
      end
      if ((rise & mpend) != 0) movf = 1'b1;
      else if (clr_ovf)        movf = 1'b0;
      mpend = mpend | rise;
      mcnt  = mcnt + int'(g >= 0) - int'(popped);
      mkeys = keys;
    end
  end

  // Monitor: state checks every cycle, head code checked against scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      chk("count", count, mcnt);
      chk("valid", code_valid, mcnt != 0);
      chk("overflow", overflow, movf);
      if (code_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL code_unexpected: got %0d want none", code_data);
        end else begin
          chk("code", code_data, exp_q[0]);
          if (code_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("data_idle", code_data, 0);
      end
    end
  end

  initial begin
    #2;
    chk("rst_valid", code_valid, 0);
    chk("rst_data", code_data, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    step(2);
    rst = 1'b1;
    step(10);
    chk("held_valid", code_valid, 0);
    chk("held_count", count, 0);

    // Single press latency
    keys = 16'h0000;
    step(1);
    keys = 16'h0020;
    step(1);
    chk("lat_edge_n_valid", code_valid, 0);
    step(1);
    chk("lat_n1_valid", code_valid, 1);
    chk("lat_n1_data", code_data, 5);
    code_ready = 1'b1;
    step(1);
    code_ready = 1'b0;
    chk("pop_valid", code_valid, 0);
    chk("pop_count", count, 0);

    // Simultaneous presses drain in ascending order
    keys = 16'h0000;
    step(1);
    keys = 16'h8421;
    step(5);
    chk("simul_count", count, 4);
    chk("simul_head", code_data, 0);
    code_ready = 1'b1;
    step(4);
    code_ready = 1'b0;
    chk("simul_drained", count, 0);

    // Back-pressure: fifth press waits in pending
    keys = 16'h0000;
    step(1);
    for (int i = 0; i < 5; i++) begin
      keys = 16'(1 << i);
      step(1);
    end
    step(2);
    chk("bp_full", count, 4);
    code_ready = 1'b1;
    step(1);
    code_ready = 1'b0;
    chk("bp_after_pop", count, 4);
    chk("bp_head", code_data, 1);

    // Lost press, clear, and set-beats-clear
    keys = 16'h0000;
    step(1);
    keys = 16'h0010;
    step(1);
    chk("ovf_first_repress", overflow, 0);
    keys = 16'h0000;
    step(1);
    keys = 16'h0010;
    step(1);
    chk("ovf_set", overflow, 1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("ovf_clr", overflow, 0);
    keys = 16'h0000;
    step(1);
    keys    = 16'h0010;
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    clr_ovf    = 1'b1;
    keys       = 16'h0000;
    code_ready = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    step(8);
    code_ready = 1'b0;
    chk("drain1_count", count, 0);

    // Asynchronous reset mid-queue
    keys = 16'h0007;
    step(4);
    chk("mid_count", count, 3);
    #2 rst = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_valid", code_valid, 0);
    step(1);
    rst = 1'b1;
    step(5);
    chk("post_rst_count", count, 0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) keys = keys ^ 16'(1 << $urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) keys = 16'($urandom);
      code_ready = (n % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr_ovf    = ($urandom_range(0, 19) == 0);
      step(1);
    end
    keys       = 16'h0000;
    clr_ovf    = 1'b0;
    code_ready = 1'b1;
    step(30);
    chk("final_sb_empty", exp_q.size(), 0);
    chk("final_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
